round_key_schedule: RTL

- Iterative key-expansion engine for the mini-AES datapath: the producer side of the round-key interface consumed by the add-round-key stage.
- Accepts one 8-bit cipher key as a 2x2 state of 2-bit elements and expands it into NR+1 round keys, one per cycle, into an internal buffer.
- Streams the round keys over a valid/ready handshake: ascending order for encryption, descending order for decryption.

---
 rtl/mini_aes_pkg.sv | 31 +++
 rtl/round_key_schedule_if.sv | 29 ++
 rtl/mini_key_step.sv | 29 ++
 rtl/round_key_schedule.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mini_aes_pkg.sv
// Shared mini-AES types and helpers: 2x2 state of 2-bit elements, sbox, round constants,
// plus the key-schedule FSM encoding.
package mini_aes_pkg;

  localparam int DIM = 2;

  typedef logic [3:0][1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_STREAM
  } rks_state_e;

  function automatic logic [1:0] sbox(input logic [1:0] e);
    logic [1:0] s;
    case (e)
      2'd0:    s = 2'd1;
      2'd1:    s = 2'd3;
      2'd2:    s = 2'd0;
      default: s = 2'd2;
    endcase
    return s;
  endfunction

  // Round constants cycle 1,2,3,1,2,3,... starting at round 1
  function automatic logic [1:0] rcon(input int i);
    return 2'(((i - 1) % 3) + 1);
  endfunction

endpackage

// File: rtl/round_key_schedule_if.sv
// Key-load and round-key stream handshake bundle; master is the key-schedule engine,
// slave is the side that supplies keys and consumes round keys.
interface round_key_schedule_if #(
  parameter int IDXW = 3
) ();
  import mini_aes_pkg::*;

  logic            key_valid;
  logic            key_ready;
  state_t          key_in;
  logic            decrypt;
  logic            abort;
  logic            rk_valid;
  logic            rk_ready;
  state_t          rk_out;
  logic [IDXW-1:0] rk_index;
  logic            rk_last;

  modport master (
    input  key_valid, key_in, decrypt, abort, rk_ready,
    output key_ready, rk_valid, rk_out, rk_index, rk_last
  );

  modport slave (
    output key_valid, key_in, decrypt, abort, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_index, rk_last
  );

endinterface

// File: rtl/mini_key_step.sv
// One combinational key-expansion step: RK[i-1] -> RK[i] for round index i.
module mini_key_step
  import mini_aes_pkg::*;
#(
  parameter int IDXW = 3
) (
  input  state_t          prev_key,
  input  logic [IDXW-1:0] round,
  output state_t          next_key
);

  logic [DIM-1:0][1:0] w0, w1, sub, g, w2, w3;

  assign w0 = prev_key[3:2];
  assign w1 = prev_key[1:0];

  // RotWord is folded into the sbox input select
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_sub
      assign sub[gi] = sbox(w1[DIM-1-gi]);
    end
  endgenerate

  assign g        = {sub[1] ^ rcon(int'(round)), sub[0]};
  assign w2       = w0 ^ g;
  assign w3       = w2 ^ w1;
  assign next_key = {w2, w3};

endmodule

// File: rtl/round_key_schedule.sv
// Iterative mini-AES key expansion: loads a cipher key, expands NR round keys into a
// flop buffer, then streams them ascending (encrypt) or descending (decrypt).
module round_key_schedule
  import mini_aes_pkg::*;
#(
  parameter int NR   = 4,
  parameter int IDXW = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  round_key_schedule_if.master bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

  rks_state_e      state_reg, state_next;
  logic [IDXW-1:0] cnt_reg, cnt_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic            decrypt_reg, decrypt_next;
  logic            key_ready_reg, key_ready_next;
  logic            rk_valid_reg, rk_valid_next;
  state_t          rk_out_reg, rk_out_next;
  logic [IDXW-1:0] rk_index_reg, rk_index_next;
  logic            rk_last_reg, rk_last_next;

  state_t buf_reg [NR+1];
  state_t step_prev;
  state_t step_out;
  logic   key_load;
  logic   expand_we;

  assign step_prev = buf_reg[cnt_reg - 1'b1];

  mini_key_step #(
    .IDXW(IDXW)
  ) u_step (
    .prev_key(step_prev),
    .round   (cnt_reg),
    .next_key(step_out)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    decrypt_next   = decrypt_reg;
    key_ready_next = key_ready_reg;
    rk_valid_next  = rk_valid_reg;
    rk_out_next    = rk_out_reg;
    rk_index_next  = rk_index_reg;
    rk_last_next   = rk_last_reg;
    key_load       = 1'b0;
    expand_we      = 1'b0;

    if (bus.abort) begin
      // Flush wins over any same-cycle key or round-key handshake
      state_next     = ST_IDLE;
      key_ready_next = 1'b1;
      rk_valid_next  = 1'b0;
      rk_last_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.key_valid) begin
            key_load       = 1'b1;
            state_next     = ST_EXPAND;
            cnt_next       = IDXW'(1);
            decrypt_next   = bus.decrypt;
            key_ready_next = 1'b0;
          end
        end
        ST_EXPAND: begin
          expand_we = 1'b1;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next = ST_STREAM;
            ptr_next   = decrypt_reg ? LAST_IDX : '0;
          end
        end
        ST_STREAM: begin
          // ptr_reg names the next key to place in the output register
          if (rk_valid_reg && bus.rk_ready && rk_last_reg) begin
            state_next     = ST_IDLE;
            key_ready_next = 1'b1;
            rk_valid_next  = 1'b0;
            rk_last_next   = 1'b0;
          end else if (!rk_valid_reg || bus.rk_ready) begin
            rk_valid_next = 1'b1;
            rk_out_next   = buf_reg[ptr_reg];
            rk_index_next = ptr_reg;
            rk_last_next  = decrypt_reg ? (ptr_reg == '0) : (ptr_reg == LAST_IDX);
            ptr_next      = decrypt_reg ? (ptr_reg - 1'b1) : (ptr_reg + 1'b1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      decrypt_reg   <= 1'b0;
      key_ready_reg <= 1'b1;
      rk_valid_reg  <= 1'b0;
      rk_out_reg    <= '0;
      rk_index_reg  <= '0;
      rk_last_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      decrypt_reg   <= decrypt_next;
      key_ready_reg <= key_ready_next;
      rk_valid_reg  <= rk_valid_next;
      rk_out_reg    <= rk_out_next;
      rk_index_reg  <= rk_index_next;
      rk_last_reg   <= rk_last_next;
    end
  end

  // Key buffer is deliberately left out of reset
  generate
    for (genvar gi = 0; gi <= NR; gi++) begin : g_buf
      if (gi == 0) begin : g_key
        always_ff @(posedge clk) begin
          if (key_load) begin
            buf_reg[0] <= bus.key_in;
          end
        end
      end else begin : g_rk
        always_ff @(posedge clk) begin
          if (expand_we && cnt_reg == IDXW'(gi)) begin
            buf_reg[gi] <= step_out;
          end
        end
      end
    end
  endgenerate

  assign bus.key_ready = key_ready_reg;
  assign bus.rk_valid  = rk_valid_reg;
  assign bus.rk_out    = rk_out_reg;
  assign bus.rk_index  = rk_index_reg;
  assign bus.rk_last   = rk_last_reg;

endmodule
